// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: read-side bundle of the UART receiver.
//   master : receiver side; drives the head word, its error flags, rx_valid,
//            fifo_count and overrun; takes rx_ready and clr_overrun.
//   slave  : consumer side; mirror of master.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  logic [DATA_BITS-1:0]               rx_data;
  logic                               rx_frame_err;
  logic                               rx_parity_err;
  logic                               rx_break;
  logic                               rx_valid;
  logic                               rx_ready;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count;
  logic                               overrun;
  logic                               clr_overrun;

  modport master (
    output rx_data, rx_frame_err, rx_parity_err, rx_break, rx_valid,
           fifo_count, overrun,
    input  rx_ready, clr_overrun
  );

  modport slave (
    input  rx_data, rx_frame_err, rx_parity_err, rx_break, rx_valid,
           fifo_count, overrun,
    output rx_ready, clr_overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with majority-voted bit recovery,
// configurable frame format and a first-word-fall-through receive FIFO.
//   clk, rst : system clock, asynchronous active-high reset
//   rx       : serial input (asynchronous, idles high)
//   rx_if    : head word + frame/parity/break flags, rx_valid/rx_ready pop
//              handshake, fifo_count, sticky overrun with clr_overrun
//
// state  | meaning
// IDLE   | line idle, waiting for a synchronised falling edge
// START  | validating the start bit (voted 1 = glitch)
// DATA   | shifting in DATA_BITS bits, LSB first
// PARITY | checking the parity bit
// STOP   | sampling STOP_BITS stop bits; push on the last decision
module uart_rx_fifo #(
  parameter int CLK_VAL_MHZ = 50,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  uart_rx_fifo_if.master     rx_if
);

  localparam int TICK_DIV = (CLK_VAL_MHZ * 1000000) / (BAUD_RATE * OVERSAMPLE);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 3;

  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SAMP_A      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_B      = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_C      = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SAMP_LAST   = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_sync_q, rx_sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]          samp_q, samp_d;
  logic                   s0_q, s0_d;
  logic                   s1_q, s1_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   all_zero_q, all_zero_d;

  logic [WW-1:0]          mem_q [FIFO_DEPTH];
  logic [WW-1:0]          mem_d [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overrun_q, overrun_d;

  logic                   tick;
  logic                   rx_fall;
  logic                   voted;
  logic                   par_calc;
  logic                   push_req;
  logic [WW-1:0]          push_word;
  logic                   rx_valid;
  logic                   do_pop;
  logic                   do_push;
  logic                   full;
  logic [WW-1:0]          head;

  assign tick    = (tick_cnt_q == '0);
  assign rx_fall = rx_prev_q & ~rx_sync_q;
  // Third sample is taken live at the decision tick.
  assign voted    = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
  assign par_calc = (^shift_q) ^ voted;

  // Receive FSM, tick generator and bit sampler
  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    state_d    = state_q;
    tick_cnt_d = tick ? TICK_RELOAD : tick_cnt_q - TW'(1);
    samp_d     = samp_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    all_zero_d = all_zero_q;
    push_req   = 1'b0;
    push_word  = {all_zero_q & ~voted, par_err_q, frm_err_q | ~voted, shift_q};

    if (state_q == S_IDLE) begin
      if (rx_fall) begin
        // Realign the tick phase to the start edge.
        tick_cnt_d = TICK_RELOAD;
        samp_d     = '0;
        bit_cnt_d  = '0;
        par_err_d  = 1'b0;
        frm_err_d  = 1'b0;
        all_zero_d = 1'b1;
        state_d    = S_START;
      end
    end else if (tick) begin
      samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + SW'(1);
      if (samp_q == SAMP_A) s0_d = rx_sync_q;
      if (samp_q == SAMP_B) s1_d = rx_sync_q;
      if (samp_q == SAMP_C) begin
        case (state_q)
          S_START: begin
            state_d = voted ? S_IDLE : S_DATA;
          end
          S_DATA: begin
            shift_d    = {voted, shift_q[DATA_BITS-1:1]};
            all_zero_d = all_zero_q & ~voted;
            if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
              bit_cnt_d = '0;
              state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
          S_PARITY: begin
            all_zero_d = all_zero_q & ~voted;
            // Odd parity expects the XOR over data+parity to be 1.
            par_err_d  = (PARITY == 1) ? ~par_calc : par_calc;
            state_d    = S_STOP;
          end
          S_STOP: begin
            all_zero_d = all_zero_q & ~voted;
            if (!voted) frm_err_d = 1'b1;
            if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
              push_req  = 1'b1;
              bit_cnt_d = '0;
              state_d   = S_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // FIFO: word = {break, parity_err, frame_err, data}
  always_comb begin
    rx_valid  = (count_q != '0);
    full      = (count_q == CW'(FIFO_DEPTH));
    do_pop    = rx_valid & rx_if.rx_ready;
    // A pop in the same clk frees the slot the push needs.
    do_push   = push_req & (~full | do_pop);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_req && full && !do_pop) overrun_d = 1'b1;
    else if (rx_if.clr_overrun)      overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      all_zero_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      all_zero_q <= all_zero_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
    end
  end

  // Outputs read as zero while the FIFO is empty.
  assign head                = mem_q[rd_ptr_q];
  assign rx_if.rx_valid      = rx_valid;
  assign rx_if.rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_if.rx_frame_err  = rx_valid & head[DATA_BITS];
  assign rx_if.rx_parity_err = rx_valid & head[DATA_BITS+1];
  assign rx_if.rx_break      = rx_valid & head[DATA_BITS+2];
  assign rx_if.fifo_count    = count_q;
  assign rx_if.overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo.
//   dut_a : defaults (8N1, 432 clk/bit, depth 8)
//   dut_b : even parity, 96 clk/bit
//   dut_c : depth 4, 96 clk/bit
module tb_uart_rx_fifo;

  localparam int BA = 432;
  localparam int BB = 96;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic rx_c = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(8)) if_a ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(8)) if_b ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_c ();

  uart_rx_fifo dut_a (.clk(clk), .rst(rst), .rx(rx_a), .rx_if(if_a));
  uart_rx_fifo #(.PARITY(2), .BAUD_RATE(460800)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_if(if_b));
  uart_rx_fifo #(.FIFO_DEPTH(4), .BAUD_RATE(460800)) dut_c (
    .clk(clk), .rst(rst), .rx(rx_c), .rx_if(if_c));

  task automatic wait_clks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(int sel, logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Frame bit vectors, LSB = first bit on the line.
  function automatic logic [15:0] fr8(logic [7:0] d, logic stp);
    return {6'b0, stp, d, 1'b0};
  endfunction

  function automatic logic [15:0] fr8p(logic [7:0] d, logic p, logic stp);
    return {5'b0, stp, p, d, 1'b0};
  endfunction

  // glitch_bit >= 0 pulls that (high) bit low for 20 clks around its middle sample.
  task automatic send_bits(int sel, int bclk, logic [15:0] bits, int n, int glitch_bit);
    for (int i = 0; i < n; i++) begin
      set_rx(sel, bits[i]);
      if (i == glitch_bit) begin
        wait_clks(235);
        set_rx(sel, 1'b0);
        wait_clks(20);
        set_rx(sel, 1'b1);
        wait_clks(bclk - 255);
      end else begin
        wait_clks(bclk);
      end
    end
  endtask

  task automatic send_frame(int sel, int bclk, logic [15:0] bits, int n);
    send_bits(sel, bclk, bits, n, -1);
    set_rx(sel, 1'b1);
    wait_clks(bclk);
  endtask

  task automatic pop(int sel);
    case (sel)
      0:       if_a.rx_ready = 1'b1;
      1:       if_b.rx_ready = 1'b1;
      default: if_c.rx_ready = 1'b1;
    endcase
    wait_clks(1);
    if_a.rx_ready = 1'b0;
    if_b.rx_ready = 1'b0;
    if_c.rx_ready = 1'b0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    if_a.rx_ready = 1'b0; if_a.clr_overrun = 1'b0;
    if_b.rx_ready = 1'b0; if_b.clr_overrun = 1'b0;
    if_c.rx_ready = 1'b0; if_c.clr_overrun = 1'b0;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(2);

    check("rst_valid",   32'(if_a.rx_valid), 0);
    check("rst_count",   32'(if_a.fifo_count), 0);
    check("rst_data",    32'(if_a.rx_data), 0);
    check("rst_overrun", 32'(if_a.overrun), 0);

    // Even parity: 0x03 has two ones, so parity bit 1 is wrong, 0 is right.
    send_frame(1, BB, fr8p(8'h03, 1'b1, 1'b1), 11);
    check("par_bad_data", 32'(if_b.rx_data), 32'h03);
    check("par_bad_err",  32'(if_b.rx_parity_err), 1);
    check("par_bad_frm",  32'(if_b.rx_frame_err), 0);
    pop(1);
    send_frame(1, BB, fr8p(8'h03, 1'b0, 1'b1), 11);
    check("par_ok_data",  32'(if_b.rx_data), 32'h03);
    check("par_ok_err",   32'(if_b.rx_parity_err), 0);
    pop(1);

    // Depth-4 FIFO overflow with the consumer stalled.
    for (int d = 1; d <= 5; d++) send_frame(2, BB, fr8(8'(d), 1'b1), 10);
    check("ovf_count",   32'(if_c.fifo_count), 4);
    check("ovf_overrun", 32'(if_c.overrun), 1);
    for (int d = 1; d <= 4; d++) begin
      check("ovf_pop_data", 32'(if_c.rx_data), 32'(d));
      pop(2);
    end
    check("ovf_empty",        32'(if_c.fifo_count), 0);
    check("ovf_sticky",       32'(if_c.overrun), 1);
    if_c.clr_overrun = 1'b1;
    wait_clks(1);
    if_c.clr_overrun = 1'b0;
    check("ovf_cleared",      32'(if_c.overrun), 0);

    // Full FIFO, pop lands in the push clk: stop decision is 927 clks after the start edge.
    send_frame(2, BB, fr8(8'h11, 1'b1), 10);
    send_frame(2, BB, fr8(8'h22, 1'b1), 10);
    send_frame(2, BB, fr8(8'h33, 1'b1), 10);
    send_frame(2, BB, fr8(8'h44, 1'b1), 10);
    check("full_count", 32'(if_c.fifo_count), 4);
    send_bits(2, BB, fr8(8'h55, 1'b1), 9, -1);
    set_rx(2, 1'b1);
    wait_clks(62);
    if_c.rx_ready = 1'b1;
    wait_clks(1);
    if_c.rx_ready = 1'b0;
    wait_clks(33 + BB);
    check("pp_count",   32'(if_c.fifo_count), 4);
    check("pp_overrun", 32'(if_c.overrun), 0);
    check("pp_head",    32'(if_c.rx_data), 32'h22);
    pop(2); pop(2); pop(2);
    check("pp_tail",    32'(if_c.rx_data), 32'h55);
    pop(2);
    check("pp_empty",   32'(if_c.fifo_count), 0);

    // 8N1 0xA5; stop decision is 4161 clks after the start edge.
    send_bits(0, BA, fr8(8'hA5, 1'b1), 9, -1);
    set_rx(0, 1'b1);
    wait_clks(272);
    check("lat_before", 32'(if_a.rx_valid), 0);
    wait_clks(1);
    check("lat_after",  32'(if_a.rx_valid), 1);
    wait_clks(159 + BA);
    check("a5_data",  32'(if_a.rx_data), 32'hA5);
    check("a5_frm",   32'(if_a.rx_frame_err), 0);
    check("a5_par",   32'(if_a.rx_parity_err), 0);
    check("a5_brk",   32'(if_a.rx_break), 0);
    check("a5_count", 32'(if_a.fifo_count), 1);
    pop(0);
    check("a5_popped", 32'(if_a.fifo_count), 0);
    check("a5_novalid", 32'(if_a.rx_valid), 0);

    // Framing error, then a 12-bit break.
    send_frame(0, BA, fr8(8'h55, 1'b0), 10);
    check("fe_data", 32'(if_a.rx_data), 32'h55);
    check("fe_frm",  32'(if_a.rx_frame_err), 1);
    check("fe_brk",  32'(if_a.rx_break), 0);
    pop(0);
    set_rx(0, 1'b0);
    wait_clks(12 * BA);
    set_rx(0, 1'b1);
    wait_clks(BA);
    check("brk_count", 32'(if_a.fifo_count), 1);
    check("brk_data",  32'(if_a.rx_data), 0);
    check("brk_flag",  32'(if_a.rx_break), 1);
    check("brk_frm",   32'(if_a.rx_frame_err), 1);
    pop(0);

    // Short start pulse is rejected; following frame is clean.
    set_rx(0, 1'b0);
    wait_clks(100);
    set_rx(0, 1'b1);
    wait_clks(2 * BA);
    check("glitch_start_count", 32'(if_a.fifo_count), 0);
    send_frame(0, BA, fr8(8'h3C, 1'b1), 10);
    check("3c_data", 32'(if_a.rx_data), 32'h3C);
    check("3c_frm",  32'(if_a.rx_frame_err), 0);
    pop(0);

    // One-sample glitch inside data bit 3 of 0xFF; left in the FIFO for the reset test.
    send_bits(0, BA, fr8(8'hFF, 1'b1), 10, 4);
    set_rx(0, 1'b1);
    wait_clks(BA);
    check("vote_data",  32'(if_a.rx_data), 32'hFF);
    check("vote_count", 32'(if_a.fifo_count), 1);

    // Reset during data bit 2 of 0x77; line then stays idle.
    send_bits(0, BA, fr8(8'h77, 1'b1), 3, -1);
    set_rx(0, 1'b1);
    wait_clks(200);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(11 * BA);
    check("mrst_count",   32'(if_a.fifo_count), 0);
    check("mrst_valid",   32'(if_a.rx_valid), 0);
    check("mrst_data",    32'(if_a.rx_data), 0);
    check("mrst_frm",     32'(if_a.rx_frame_err), 0);
    check("mrst_par",     32'(if_a.rx_parity_err), 0);
    check("mrst_brk",     32'(if_a.rx_break), 0);
    check("mrst_overrun", 32'(if_a.overrun), 0);
    send_frame(0, BA, fr8(8'h88, 1'b1), 10);
    check("88_data",  32'(if_a.rx_data), 32'h88);
    check("88_frm",   32'(if_a.rx_frame_err), 0);
    check("88_par",   32'(if_a.rx_parity_err), 0);
    check("88_brk",   32'(if_a.rx_break), 0);
    check("88_count", 32'(if_a.fifo_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
